// File: rtl/stream_mux2.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux2
// Description : 2-to-1 valid/ready byte-stream merger with packet locking.
//               Two producer streams are arbitrated onto one registered
//               output stream. Packets (byte runs ending with a last flag)
//               are never interleaved. When both producers are waiting at a
//               packet boundary they are served round robin.
//               Optional build macro FIXED_PRIO_EN: when defined, a tie at a
//               packet boundary always goes to channel 0, and the last-grant
//               pointer (and RESET_GRANT) drop out of the design.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               Data_in_n/valid_n/last_n/ready_n (n=0,1) - producer streams
//               Data_out/valid_out/last_out/sel_out       - registered output
//               ready_out           - sink accepts the byte on Data_out
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux2 #(
    parameter int DATA_W      = 8,
    parameter bit RESET_GRANT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Data_in_0,
    input  logic              valid_0,
    input  logic              last_0,
    output logic              ready_0,
    input  logic [DATA_W-1:0] Data_in_1,
    input  logic              valid_1,
    input  logic              last_1,
    output logic              ready_1,
    output logic [DATA_W-1:0] Data_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              sel_out,
    input  logic              ready_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_slot_free;
    logic              w_gnt_vld;
    logic              w_gnt;
    logic              w_acc;
    logic              w_acc_last;
    logic [DATA_W-1:0] w_acc_data;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_sel;

`ifndef FIXED_PRIO_EN
    logic              r_last_grant;
`endif

    // The output register can take a new byte when empty or draining this cycle.
    assign w_slot_free = !r_valid | ready_out;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Any accepted non-last byte locks onto its channel
    // (entering or staying in LOCKn); an accepted last byte releases.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == 2'd3) begin
            w_state_nxt = S_IDLE;
        end else if (w_acc) begin
            if (w_acc_last) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = w_gnt ? S_LOCK1 : S_LOCK0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (grant decision)
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        case (r_state)
            S_LOCK0: begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b0;
            end
            S_LOCK1: begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b1;
            end
            default: begin
                if (valid_0 && valid_1) begin
                    w_gnt_vld = 1'b1;
`ifdef FIXED_PRIO_EN
                    w_gnt     = 1'b0;
`else
                    w_gnt     = ~r_last_grant;
`endif
                end else if (valid_0) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = 1'b0;
                end else if (valid_1) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = 1'b1;
                end
            end
        endcase
    end

    assign ready_0 = w_slot_free & w_gnt_vld & ~w_gnt;
    assign ready_1 = w_slot_free & w_gnt_vld &  w_gnt;

    assign w_acc      = w_gnt ? (valid_1 & ready_1) : (valid_0 & ready_0);
    assign w_acc_last = w_gnt ? last_1    : last_0;
    assign w_acc_data = w_gnt ? Data_in_1 : Data_in_0;

    // ------------------------------------------------------------------
    // Output register. Holds while stalled; valid falls when the slot
    // drains without a replacement byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_sel   <= 1'b0;
        end else if (w_slot_free) begin
            r_valid <= w_acc;
            if (w_acc) begin
                r_data <= w_acc_data;
                r_last <= w_acc_last;
                r_sel  <= w_gnt;
            end
        end
    end

`ifndef FIXED_PRIO_EN
    // Round-robin pointer moves only at packet ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= RESET_GRANT;
        end else if (w_acc && w_acc_last) begin
            r_last_grant <= w_gnt;
        end
    end
`endif

    assign Data_out  = r_data;
    assign valid_out = r_valid;
    assign last_out  = r_last;
    assign sel_out   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux2
// Description : Self-checking bench for stream_mux2. Directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the merger (lock owner, round-robin
//               pointer, output slot contents).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Data_in_0, Data_in_1, Data_out;
    logic       valid_0, last_0, ready_0;
    logic       valid_1, last_1, ready_1;
    logic       valid_out, last_out, sel_out, ready_out;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int         m_lock;    // -1 = no packet in progress, else owning channel
    bit         m_lg;      // channel that finished the most recent packet
    bit         m_vo;
    logic [7:0] m_do;
    bit         m_lo;
    bit         m_so;

    always #5 clk = ~clk;

    stream_mux2 #(.DATA_W(8), .RESET_GRANT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .Data_in_0 (Data_in_0),
        .valid_0   (valid_0),
        .last_0    (last_0),
        .ready_0   (ready_0),
        .Data_in_1 (Data_in_1),
        .valid_1   (valid_1),
        .last_1    (last_1),
        .ready_1   (ready_1),
        .Data_out  (Data_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which channel the merger serves this cycle, -1 if none.
    function automatic int pick(input int lock, input bit lg, input bit v0, input bit v1);
        if (lock >= 0) return lock;
        if (v0 && v1) begin
`ifdef FIXED_PRIO_EN
            return 0;
`else
            return lg ? 0 : 1;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // One clock cycle: drive inputs, check readies, advance model, check outputs.
    task automatic step(input bit rst, input bit v0, input logic [7:0] d0, input bit l0,
                        input bit v1, input logic [7:0] d1, input bit l1, input bit ro);
        int ch;
        bit sf, acc, al;
        logic [7:0] ad;
        @(negedge clk);
        reset = rst; valid_0 = v0; Data_in_0 = d0; last_0 = l0;
        valid_1 = v1; Data_in_1 = d1; last_1 = l1; ready_out = ro;
        #1;
        ch = pick(m_lock, m_lg, v0, v1);
        sf = !m_vo || ro;
        chk("ready_0", {31'b0, ready_0}, {31'b0, sf && ch == 0});
        chk("ready_1", {31'b0, ready_1}, {31'b0, sf && ch == 1});
        acc = sf && ((ch == 0 && v0) || (ch == 1 && v1));
        al  = (ch == 1) ? l1 : l0;
        ad  = (ch == 1) ? d1 : d0;
        if (rst) begin
            m_lock = -1; m_lg = 1'b1; m_vo = 0; m_do = 8'h00; m_lo = 0; m_so = 0;
        end else begin
            if (sf) begin
                m_vo = acc;
                if (acc) begin
                    m_do = ad; m_lo = al; m_so = (ch == 1);
                end
            end
            if (acc) begin
                if (al) begin
                    m_lock = -1;
                    m_lg   = (ch == 1);
                end else begin
                    m_lock = ch;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("valid_out", {31'b0, valid_out}, {31'b0, m_vo});
        chk("Data_out",  {24'b0, Data_out},  {24'b0, m_do});
        chk("last_out",  {31'b0, last_out},  {31'b0, m_lo});
        chk("sel_out",   {31'b0, sel_out},   {31'b0, m_so});
    endtask

    initial begin
        m_lock = -1; m_lg = 1'b1; m_vo = 0; m_do = 8'h00; m_lo = 0; m_so = 0;
        reset = 1'b1; valid_0 = 0; valid_1 = 0; last_0 = 0; last_1 = 0;
        Data_in_0 = 8'h00; Data_in_1 = 8'h00; ready_out = 1'b0;

        // Reset state
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
        chk("rst_Data_out", {24'b0, Data_out}, 32'd0);

        // Single-byte packet on ch0
        step(0, 1, 8'hA5, 1, 0, 8'h00, 0, 1);
        chk("a5_data", {24'b0, Data_out}, 32'hA5);
        chk("a5_last", {31'b0, last_out}, 32'd1);
        chk("a5_sel", {31'b0, sel_out}, 32'd0);

        // Two channels of single-byte packets: round robin (or ch0 only when fixed)
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h11, 1, 1, 8'h22, 1, 1);
`ifdef FIXED_PRIO_EN
            chk("tie_sel", {31'b0, sel_out}, 32'd0);
`else
            chk("tie_sel", {31'b0, sel_out}, i % 2);
`endif
        end

        // Packet lock with bubble: ch1 blocked until ch0 packet ends
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h01, 0, 1, 8'h99, 1, 1);
        chk("lock_ready_1", {31'b0, ready_1}, 32'd0);
        chk("lock_d1", {24'b0, Data_out}, 32'h01);
        step(0, 0, 8'h00, 0, 1, 8'h99, 1, 1);
        chk("bubble_ready_1", {31'b0, ready_1}, 32'd0);
        chk("bubble_valid", {31'b0, valid_out}, 32'd0);
        step(0, 1, 8'h02, 0, 1, 8'h99, 1, 1);
        chk("lock_d2", {24'b0, Data_out}, 32'h02);
        step(0, 1, 8'h03, 1, 1, 8'h99, 1, 1);
        chk("lock_d3", {24'b0, Data_out}, 32'h03);
        step(0, 0, 8'h00, 0, 1, 8'h99, 1, 1);
        chk("lock_d99", {24'b0, Data_out}, 32'h99);
        chk("lock_sel99", {31'b0, sel_out}, 32'd1);

        // Output backpressure
        step(0, 1, 8'h5C, 1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h77, 1, 1, 8'h66, 1, 0);
            chk("bp_data", {24'b0, Data_out}, 32'h5C);
            chk("bp_ready_0", {31'b0, ready_0}, 32'd0);
        end
        step(0, 1, 8'h77, 1, 0, 8'h00, 0, 1);
        chk("bp_next", {24'b0, Data_out}, 32'h77);

        // Reset while ch1 owns the output
        step(0, 0, 8'h00, 0, 1, 8'h33, 0, 1);
        step(1, 0, 8'h00, 0, 1, 8'h34, 0, 1);
        chk("rst_lock_valid", {31'b0, valid_out}, 32'd0);
        step(0, 1, 8'h44, 1, 1, 8'h55, 1, 1);
        chk("rst_lock_d", {24'b0, Data_out}, 32'h44);
        chk("rst_lock_sel", {31'b0, sel_out}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
